// File: rtl/line_sched_pkg.sv
// Shared types for the line scheduler.
// Command bundle, FSM states and default geometry.
package line_sched_pkg;

   localparam int DEF_WIDTH  = 640;
   localparam int DEF_HEIGHT = 480;
   localparam int CMD_CW     = 11;

   typedef struct packed {
      logic [CMD_CW-1:0] x0;
      logic [CMD_CW-1:0] y0;
      logic [CMD_CW-1:0] x1;
      logic [CMD_CW-1:0] y1;
      logic              color;
   } line_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAW,
      CLEAR
   } sched_state_t;

endpackage

// File: rtl/line_scheduler_cmd_fifo.sv
// Small synchronous FIFO of line commands.
// Count is registered; full/empty derive from it.
module cmd_fifo
   import line_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  line_cmd_t                din,
   output line_cmd_t                dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   line_cmd_t        mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rp];

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage write; contents need no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end

endmodule

// File: rtl/line_scheduler.sv
// Sequences queued line commands into line_drawer
// and sweeps the framebuffer on a clear request.
module line_scheduler
   import line_sched_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int HEIGHT  = DEF_HEIGHT,
   parameter int COORD_W = CMD_CW,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [COORD_W-1:0] cmd_x0,
   input  logic [COORD_W-1:0] cmd_y0,
   input  logic [COORD_W-1:0] cmd_x1,
   input  logic [COORD_W-1:0] cmd_y1,
   input  logic               cmd_color,
   input  logic               clear_req,
   output logic               ld_reset,
   output logic [COORD_W-1:0] ld_x0,
   output logic [COORD_W-1:0] ld_y0,
   output logic [COORD_W-1:0] ld_x1,
   output logic [COORD_W-1:0] ld_y1,
   input  logic [COORD_W-1:0] ld_x,
   input  logic [COORD_W-1:0] ld_y,
   input  logic               ld_done,
   output logic [COORD_W-1:0] fb_x,
   output logic [COORD_W-1:0] fb_y,
   output logic               fb_color,
   output logic               fb_write,
   output logic               busy
);

   sched_state_t           state;
   sched_state_t           nxt;
   line_cmd_t              cmd_in;
   line_cmd_t              head;
   line_cmd_t              cmd_q;
   logic                   full;
   logic                   empty;
   logic [$clog2(DEPTH):0] count;
   logic                   push;
   logic                   pop;
   logic                   take_clear;
   logic                   clear_pending;
   logic [COORD_W-1:0]     cx;
   logic [COORD_W-1:0]     cy;
   logic                   x_last;
   logic                   y_last;
   logic                   in_bounds;

   assign cmd_in    = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
   assign cmd_ready = reset_n && !full;
   assign push      = cmd_valid && cmd_ready;
   assign x_last    = (cx == COORD_W'(WIDTH - 1));
   assign y_last    = (cy == COORD_W'(HEIGHT - 1));
   assign in_bounds = (ld_x < COORD_W'(WIDTH)) && (ld_y < COORD_W'(HEIGHT));

   assign ld_x0 = cmd_q.x0;
   assign ld_y0 = cmd_q.y0;
   assign ld_x1 = cmd_q.x1;
   assign ld_y1 = cmd_q.y1;

   assign busy = !((state == IDLE) && (count == '0) && !clear_pending);

   cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (cmd_in),
      .dout    (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   // next state and framebuffer/drawer outputs
   always_comb begin
      nxt        = state;
      pop        = 1'b0;
      take_clear = 1'b0;
      ld_reset   = 1'b1;
      fb_x       = '0;
      fb_y       = '0;
      fb_color   = 1'b0;
      fb_write   = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear_pending) begin
               nxt        = CLEAR;
               take_clear = 1'b1;
            end else if (!empty) begin
               nxt = LOAD;
               pop = 1'b1;
            end
         end
         LOAD: nxt = DRAW;
         DRAW: begin
            ld_reset = 1'b0;
            fb_x     = ld_x;
            fb_y     = ld_y;
            fb_color = cmd_q.color;
            fb_write = in_bounds;
            if (ld_done) nxt = IDLE;
         end
         CLEAR: begin
            fb_x     = cx;
            fb_y     = cy;
            fb_write = 1'b1;
            if (x_last && y_last) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // command latch, clear request merge and sweep counters
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cmd_q         <= '0;
         clear_pending <= 1'b0;
         cx            <= '0;
         cy            <= '0;
      end else begin
         if (pop) cmd_q <= head;
         if (take_clear)
            clear_pending <= 1'b0;
         else if (state != CLEAR)
            clear_pending <= clear_pending | clear_req;
         if (take_clear) begin
            cx <= '0;
            cy <= '0;
         end else if (state == CLEAR) begin
            if (x_last) begin
               cx <= '0;
               if (!y_last) cy <= cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_line_scheduler.sv
// Directed bench for line_scheduler with a simple
// line_drawer model (horizontal/vertical/45-degree lines).
module tb_line_scheduler;
   import line_sched_pkg::*;

   localparam int W  = 244;
   localparam int H  = 242;
   localparam int CW = 11;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [CW-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
   logic          cmd_color;
   logic          clear_req;
   logic          ld_reset;
   logic [CW-1:0] ld_x0, ld_y0, ld_x1, ld_y1;
   logic [CW-1:0] ld_x, ld_y;
   logic          ld_done;
   logic [CW-1:0] fb_x, fb_y;
   logic          fb_color;
   logic          fb_write;
   logic          busy;

   int n_run  = 0;
   int n_fail = 0;

   logic [22:0] wq  [$];
   logic [22:0] exq [$];

   always #5 clk = ~clk;

   line_scheduler #(
      .WIDTH   (W),
      .HEIGHT  (H),
      .COORD_W (CW),
      .DEPTH   (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_x0    (cmd_x0),
      .cmd_y0    (cmd_y0),
      .cmd_x1    (cmd_x1),
      .cmd_y1    (cmd_y1),
      .cmd_color (cmd_color),
      .clear_req (clear_req),
      .ld_reset  (ld_reset),
      .ld_x0     (ld_x0),
      .ld_y0     (ld_y0),
      .ld_x1     (ld_x1),
      .ld_y1     (ld_y1),
      .ld_x      (ld_x),
      .ld_y      (ld_y),
      .ld_done   (ld_done),
      .fb_x      (fb_x),
      .fb_y      (fb_y),
      .fb_color  (fb_color),
      .fb_write  (fb_write),
      .busy      (busy)
   );

   // line_drawer stand-in: one unit step per axis per cycle
   logic [CW-1:0] mx = '0;
   logic [CW-1:0] my = '0;
   assign ld_x    = mx;
   assign ld_y    = my;
   assign ld_done = (mx == ld_x1) && (my == ld_y1);

   always @(posedge clk) begin
      if (ld_reset) begin
         mx <= ld_x0;
         my <= ld_y0;
      end else if (!ld_done) begin
         if (mx < ld_x1)      mx <= mx + 11'd1;
         else if (mx > ld_x1) mx <= mx - 11'd1;
         if (my < ld_y1)      my <= my + 11'd1;
         else if (my > ld_y1) my <= my - 11'd1;
      end
   end

   // framebuffer write capture
   always @(negedge clk) begin
      if (fb_write === 1'b1) wq.push_back({fb_x, fb_y, fb_color});
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_line(input int x0, input int y0, input int x1,
                              input int y1, input bit c);
      int x = x0;
      int y = y0;
      forever begin
         if (x < W && y < H) exq.push_back({11'(x), 11'(y), c});
         if (x == x1 && y == y1) break;
         if (x < x1) x++; else if (x > x1) x--;
         if (y < y1) y++; else if (y > y1) y--;
      end
   endtask

   task automatic cmp_writes(input string tag);
      int bad = 0;
      int n   = (wq.size() < exq.size()) ? wq.size() : exq.size();
      check({tag, "_count"}, wq.size(), exq.size());
      for (int i = 0; i < n; i++)
         if (wq[i] !== exq[i]) bad++;
      check({tag, "_pixels_bad"}, bad, 0);
      wq.delete();
      exq.delete();
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, 32'(busy === 1'b0), 1);
   endtask

   task automatic send(input int x0, input int y0, input int x1,
                       input int y1, input bit c);
      cmd_x0    = 11'(x0);
      cmd_y0    = 11'(y0);
      cmd_x1    = 11'(x1);
      cmd_y1    = 11'(y1);
      cmd_color = c;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   int lx0 [5] = '{0, 20, 30, 242, 1};
   int ly0 [5] = '{10, 0, 30, 3, 1};
   int lx1 [5] = '{7, 20, 26, 245, 3};
   int ly1 [5] = '{10, 5, 26, 3, 3};
   bit lc  [5] = '{1, 0, 1, 1, 0};

   initial begin
      int n;
      int n0;
      logic [22:0] got;

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      clear_req = 1'b0;
      cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
      cmd_color = 1'b0;

      // 1: reset state
      repeat (3) @(negedge clk);
      check("rst_ld_reset", ld_reset, 1);
      check("rst_fb_write", fb_write, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_fb_xy", {fb_x, fb_y}, 0);
      check("rst_ld_ep", {ld_x0, ld_y0, ld_x1}, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", cmd_ready, 1);
      check("post_rst_busy", busy, 0);
      check("post_rst_ld_reset", ld_reset, 1);
      wq.delete();

      // 2: single line, latency
      send(0, 0, 3, 0, 1'b1);
      check("t2_acc_fbw", fb_write, 0);
      check("t2_acc_busy", busy, 1);
      @(negedge clk);
      check("t2_load_ld_reset", ld_reset, 1);
      check("t2_load_fbw", fb_write, 0);
      check("t2_load_x1", ld_x1, 3);
      @(negedge clk);
      check("t2_draw_fbw", fb_write, 1);
      check("t2_draw_ld_reset", ld_reset, 0);
      check("t2_draw_x", fb_x, 0);
      repeat (3) @(negedge clk);
      check("t2_last_x", fb_x, 3);
      check("t2_last_busy", busy, 1);
      @(negedge clk);
      check("t2_done_busy", busy, 0);
      check("t2_done_fbw", fb_write, 0);
      expect_line(0, 0, 3, 0, 1'b1);
      cmp_writes("t2");

      // 3: five back-to-back commands, FIFO fills
      for (int i = 0; i < 5; i++) begin
         check("t3_ready", cmd_ready, 1);
         cmd_x0    = 11'(lx0[i]);
         cmd_y0    = 11'(ly0[i]);
         cmd_x1    = 11'(lx1[i]);
         cmd_y1    = 11'(ly1[i]);
         cmd_color = lc[i];
         cmd_valid = 1'b1;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("t3_full_ready", cmd_ready, 0);
      for (int i = 0; i < 5; i++)
         expect_line(lx0[i], ly0[i], lx1[i], ly1[i], lc[i]);
      wait_idle("t3", 500);
      cmp_writes("t3");

      // 4: clear during a line, one command queued behind it
      send(10, 10, 20, 20, 1'b1);
      repeat (3) @(negedge clk);
      check("t4_drawing", fb_write, 1);
      clear_req = 1'b1;
      cmd_x0 = 11'd1; cmd_y0 = 11'd2;
      cmd_x1 = 11'd1; cmd_y1 = 11'd4;
      cmd_color = 1'b1;
      cmd_valid = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      cmd_valid = 1'b0;
      expect_line(10, 10, 20, 20, 1'b1);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            exq.push_back({11'(x), 11'(y), 1'b0});
      expect_line(1, 2, 1, 4, 1'b1);
      wait_idle("t4", 70000);
      n   = 11 + W * H - 1;
      got = (wq.size() > n) ? wq[n] : '1;
      check("t4_clear_last", got, {11'(W - 1), 11'(H - 1), 1'b0});
      cmp_writes("t4");

      // 5: degenerate line
      send(240, 240, 240, 240, 1'b1);
      wait_idle("t5", 50);
      expect_line(240, 240, 240, 240, 1'b1);
      cmp_writes("t5");

      // 6: reset in the middle of a clear with commands queued
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      @(negedge clk);
      send(5, 5, 9, 5, 1'b1);
      send(6, 6, 6, 9, 1'b1);
      n = 0;
      while (!(fb_write === 1'b1 && fb_x == 11'd100 && fb_y == 11'd5)
             && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("t6_reach_100_5", 32'(n < 5000), 1);
      reset_n = 1'b0;
      @(negedge clk);
      check("t6_rst_fbw", fb_write, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_ld_reset", ld_reset, 1);
      reset_n = 1'b1;
      @(negedge clk);
      check("t6_ready", cmd_ready, 1);
      check("t6_empty_busy", busy, 0);
      n0 = wq.size();
      check("t6_clear_writes", n0, 5 * W + 101);
      repeat (40) @(negedge clk);
      check("t6_quiet", wq.size(), n0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
